outdisp_ctrl: RTL and testbench

Sequencing controller for the output stage of the 8-bit computer. It captures bus writes to the output port and converts the binary value to three BCD digits with an iterative shift-add-3 FSM. It then time-multiplexes the digits onto a 4-digit seven-segment display. It sits between the CPU bus (`busin`/`wa`, the same strobe that loads the output register) and the board display pins.

---
 rtl/outdisp_pkg.sv | 23 ++
 rtl/seg7_decode.sv | 18 +
 rtl/outdisp_ctrl.sv | 164 ++++++++++++++++
 tb/tb_outdisp_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/outdisp_pkg.sv
// Shared types and constants for the output-display controller.
// OUTDISP_SIGNED_EN (defined in the top) selects signed display mode.
package outdisp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;

  // Digit code routed through the decoder to request the minus sign
  localparam logic [3:0] DIG_MINUS = 4'hA;

  // Segment font for 0..9, gfedcba, active-high; entry 0 is digit 0
  localparam logic [9:0][6:0] FONT = {
    7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder with blanking and minus-sign code.
module seg7_decode
  import outdisp_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      if (i_digit == DIG_MINUS) o_seg = SEG_MINUS;
      else if (i_digit <= 4'd9) o_seg = FONT[i_digit];
    end
  end

endmodule

// File: rtl/outdisp_ctrl.sv
// Output-port capture, iterative binary-to-BCD conversion and 4-digit scan.
// Define OUTDISP_SIGNED_EN to display the byte as two's complement with a minus sign.
module outdisp_ctrl
  import outdisp_pkg::*;
#(
  parameter int SCAN_BITS = 10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] busin,
  input  logic       wa,
  output logic [7:0] value,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg
);

  state_t                 r_state;
  logic [7:0]             r_value;
  logic [7:0]             r_sh;
  logic [11:0]            r_bcd;
  logic [2:0]             r_cnt;
  logic                   r_dirty;
  logic                   r_busy;
  logic [3:0]             r_hun, r_ten, r_uni;
  logic [SCAN_BITS-1:0]   r_scan;
`ifdef OUTDISP_SIGNED_EN
  logic                   r_sign;
  logic                   r_neg;
`endif

  logic [7:0] w_load_byte;
  logic [1:0] w_sel;
  logic [3:0] w_digit;
  logic       w_blank;

  function automatic logic [7:0] load_mag(input logic [7:0] b);
`ifdef OUTDISP_SIGNED_EN
    logic signed [7:0] s;
    s = signed'(b);
    // -(-128) wraps back to 8'h80, which is the wanted magnitude 128
    return (s < 0) ? 8'(-s) : b;
`else
    return b;
`endif
  endfunction

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  // A COMMIT restart without a fresh write reconverts the pending byte
  always_comb begin
    w_load_byte = busin;
    if (r_state == ST_COMMIT && !wa) w_load_byte = r_value;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= ST_IDLE;
      r_value <= 8'h00;
      r_dirty <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= 3'd0;
      r_hun   <= 4'd0;
      r_ten   <= 4'd0;
      r_uni   <= 4'd0;
      r_scan  <= '0;
`ifdef OUTDISP_SIGNED_EN
      r_sign  <= 1'b0;
      r_neg   <= 1'b0;
`endif
    end else begin
      r_scan <= r_scan + 1'b1;
      if (wa) r_value <= busin;
      case (r_state)
        ST_IDLE: begin
          if (wa) begin
            r_sh    <= load_mag(w_load_byte);
            r_bcd   <= 12'd0;
            r_cnt   <= 3'd0;
`ifdef OUTDISP_SIGNED_EN
            r_sign  <= w_load_byte[7];
`endif
            r_state <= ST_CONV;
            r_busy  <= 1'b1;
          end
        end
        ST_CONV: begin
          {r_bcd, r_sh} <= {add3(r_bcd), r_sh} << 1;
          r_cnt <= r_cnt + 3'd1;
          if (wa) r_dirty <= 1'b1;
          if (r_cnt == 3'd7) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_hun   <= r_bcd[11:8];
          r_ten   <= r_bcd[7:4];
          r_uni   <= r_bcd[3:0];
`ifdef OUTDISP_SIGNED_EN
          r_neg   <= r_sign;
`endif
          r_dirty <= 1'b0;
          if (wa || r_dirty) begin
            r_sh    <= load_mag(w_load_byte);
            r_bcd   <= 12'd0;
            r_cnt   <= 3'd0;
`ifdef OUTDISP_SIGNED_EN
            r_sign  <= w_load_byte[7];
`endif
            r_state <= ST_CONV;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_sel = r_scan[SCAN_BITS-1 -: 2];

  always_comb begin
    w_digit = r_uni;
    w_blank = 1'b0;
    case (w_sel)
      2'd0: w_digit = r_uni;
      2'd1: begin
        w_digit = r_ten;
        w_blank = (r_hun == 4'd0) && (r_ten == 4'd0);
      end
      2'd2: begin
        w_digit = r_hun;
        w_blank = (r_hun == 4'd0);
      end
      default: begin
        w_digit = DIG_MINUS;
`ifdef OUTDISP_SIGNED_EN
        w_blank = !r_neg;
`else
        w_blank = 1'b1;
`endif
      end
    endcase
  end

  seg7_decode u_dec (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (seg)
  );

  assign an    = 4'b0001 << w_sel;
  assign value = r_value;
  assign busy  = r_busy;

endmodule

// File: tb/tb_outdisp_ctrl.sv
// Self-checking bench for outdisp_ctrl with SCAN_BITS=4 and a decimal reference model.
module tb_outdisp_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] busin = 8'h00;
  logic       wa = 1'b0;
  logic [7:0] value;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;

  int n_vec = 0;
  int n_err = 0;
  int tcnt  = 0;            // expected scan counter, 0..15
  logic [7:0] disp_val = 8'h00;  // byte whose decimal form should be on the display

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!clr) tcnt <= 0;
    else      tcnt <= (tcnt + 1) % 16;
  end

  outdisp_ctrl #(.SCAN_BITS(4)) dut (
    .clk   (clk),
    .clr   (clr),
    .busin (busin),
    .wa    (wa),
    .value (value),
    .busy  (busy),
    .an    (an),
    .seg   (seg)
  );

  function automatic logic [6:0] font(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic logic [3:0] exp_an();
    return 4'b0001 << (tcnt / 4);
  endfunction

  function automatic logic [6:0] exp_seg(input logic [7:0] v);
    int mag, h, t, u, pos;
    bit neg;
`ifdef OUTDISP_SIGNED_EN
    neg = v[7];
    mag = neg ? 256 - int'(v) : int'(v);
`else
    neg = 1'b0;
    mag = int'(v);
`endif
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    pos = tcnt / 4;
    case (pos)
      0: return font(u);
      1: return (h == 0 && t == 0) ? 7'b0000000 : font(t);
      2: return (h == 0) ? 7'b0000000 : font(h);
      default: return neg ? 7'b1000000 : 7'b0000000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    wa = 1'b1;
    busin = 8'hAA;
    tick();
    tick();
    disp_val = 8'h00;
    n_vec++;
    if (value !== 8'h00 || busy !== 1'b0 || an !== 4'b0001 || seg !== 7'b0111111) begin
      n_err++;
      $display("FAIL reset: value=%h busy=%b an=%b seg=%b, expected value=00 busy=0 an=0001 seg=0111111",
               value, busy, an, seg);
    end
    wa = 1'b0;
    clr = 1'b1;
  endtask

  // One write from idle: value, busy window, held display, commit, full scan
  task automatic test_single_write(input logic [7:0] b, input string nm);
    busin = b;
    wa = 1'b1;
    tick();
    wa = 1'b0;
    n_vec++;
    if (value !== b || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: value=%h busy=%b, expected value=%h busy=1", nm, value, busy, b);
    end
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 9) disp_val = b;
      n_vec++;
      if (busy !== (e < 9) || an !== exp_an() || seg !== exp_seg(disp_val)) begin
        n_err++;
        $display("FAIL %s edge N+%0d: busy=%b an=%b seg=%b, expected busy=%b an=%b seg=%b",
                 nm, e, busy, an, seg, (e < 9), exp_an(), exp_seg(disp_val));
      end
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      n_vec++;
      if (busy !== 1'b0 || an !== exp_an() || seg !== exp_seg(disp_val)) begin
        n_err++;
        $display("FAIL %s scan: busy=%b an=%b seg=%b, expected busy=0 an=%b seg=%b",
                 nm, busy, an, seg, exp_an(), exp_seg(disp_val));
      end
    end
  endtask

  // Write a at edge N, then b at edge N+k (k 1..8 in CONV, 9 in COMMIT)
  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b, input int k,
                                   input string nm);
    busin = a;
    wa = 1'b1;
    tick();
    wa = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      if (e == k) begin
        busin = b;
        wa = 1'b1;
      end
      tick();
      wa = 1'b0;
      if (e == 9)  disp_val = a;
      if (e == 18) disp_val = b;
      if (e == k) begin
        n_vec++;
        if (value !== b) begin
          n_err++;
          $display("FAIL %s second write: value=%h, expected %h", nm, value, b);
        end
      end
      n_vec++;
      if (busy !== (e < 18) || an !== exp_an() || seg !== exp_seg(disp_val)) begin
        n_err++;
        $display("FAIL %s edge N+%0d: busy=%b an=%b seg=%b, expected busy=%b an=%b seg=%b",
                 nm, e, busy, an, seg, (e < 18), exp_an(), exp_seg(disp_val));
      end
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      n_vec++;
      if (busy !== 1'b0 || an !== exp_an() || seg !== exp_seg(disp_val)) begin
        n_err++;
        $display("FAIL %s scan: busy=%b an=%b seg=%b, expected busy=0 an=%b seg=%b",
                 nm, busy, an, seg, exp_an(), exp_seg(disp_val));
      end
    end
  endtask

  // Reset in the 4th conversion cycle: no commit, digits back to 000
  task automatic test_reset_abort();
    busin = 8'hFF;
    wa = 1'b1;
    tick();
    wa = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    clr = 1'b0;
    tick();
    disp_val = 8'h00;
    n_vec++;
    if (busy !== 1'b0 || value !== 8'h00 || an !== 4'b0001 || seg !== 7'b0111111) begin
      n_err++;
      $display("FAIL abort: busy=%b value=%h an=%b seg=%b, expected busy=0 value=00 an=0001 seg=0111111",
               busy, value, an, seg);
    end
    clr = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_vec++;
      if (busy !== 1'b0 || an !== exp_an() || seg !== exp_seg(disp_val)) begin
        n_err++;
        $display("FAIL abort after: busy=%b an=%b seg=%b, expected busy=0 an=%b seg=%b",
                 busy, an, seg, exp_an(), exp_seg(disp_val));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    int k;
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom_range(0, 255));
      test_single_write(a, "rand_single");
    end
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      k = $urandom_range(1, 9);
      test_back_to_back(a, b, k, "rand_b2b");
    end
  endtask

  initial begin
    test_reset();
    test_single_write(8'hF3, "write_F3");
    test_single_write(8'h07, "write_07");
    test_back_to_back(8'h22, 8'h67, 3, "b2b_22_67");
    test_back_to_back(8'h05, 8'hC8, 9, "commit_write");
    test_back_to_back(8'h99, 8'h01, 8, "last_conv_write");
    test_reset_abort();
    test_single_write(8'h80, "write_80");
    test_single_write(8'hFF, "write_FF");
    test_single_write(8'h00, "write_00");
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
